// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store sequencer: access sizes, FSM states, alignment rule.
package mem_access_pkg;

   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic [2:0] {
      IDLE, LOAD, RMW_RD, STORE, RESP, ERR
   } state_t;

   function automatic logic is_misaligned(size_t sz, logic [1:0] lo);
      case (sz)
         SZ_HALF: return lo[0];
         SZ_WORD: return |lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Clock/reset bundle and word-RAM port used by the memory access unit.
interface ctrl_bus_if;
   logic clk;
   logic rst_n;
   modport central (input clk, input rst_n);
   modport drv     (output clk, output rst_n);
endinterface

interface mem_bus_if;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        enab;
   modport central (output addr, output enab, input rdata);
   modport ram     (input addr, input enab, output rdata);
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module byte_lane
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  size_t       size,
   input  logic        uns,
   output logic [31:0] ext,
   output logic [31:0] merged
);

   logic [NUM_LANES-1:0][VEC_W-1:0] word_l, wdata_l, merged_l;
   logic [7:0]  b;
   logic [15:0] h;

   assign word_l  = word;
   assign wdata_l = wdata;
   assign merged  = merged_l;

   always_comb begin
      b   = '0;
      h   = '0;
      ext = word;
      case (size)
         SZ_BYTE: begin
            b   = word_l[offset];
            ext = {{24{b[7] & ~uns}}, b};
         end
         SZ_HALF: begin
            h   = offset[1] ? word[31:16] : word[15:0];
            ext = {{16{h[15] & ~uns}}, h};
         end
         default: ext = word;
      endcase
   end

   // Each lane takes store data only when the access covers it.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LI = 2'(i);
      logic             sel;
      logic [VEC_W-1:0] src;
      assign sel = (size == SZ_WORD) ||
                   ((size == SZ_HALF) && (offset[1] == LI[1])) ||
                   ((size == SZ_BYTE) && (offset == LI));
      assign src = (size == SZ_BYTE) ? wdata_l[0] :
                   (size == SZ_HALF) ? wdata_l[{1'b0, LI[0]}] : wdata_l[i];
      assign merged_l[i] = sel ? src : word_l[i];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-only RAM; sub-word stores use read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = 64
) (
   ctrl_bus_if.central ctrl_bus,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   mem_bus_if.central  mem_bus,
   output logic [31:0] write_data
);

   logic clk, rst_n;
   assign clk   = ctrl_bus.clk;
   assign rst_n = ctrl_bus.rst_n;

   state_t      state, state_nx;
   size_t       size_q;
   logic        uns_q;
   logic [31:0] addr_q, wdata_q, merge_q;
   logic [31:0] ext_w, merge_w;
   logic        req_bad;

   assign req_bad = (req_size == 2'b11) ||
                    is_misaligned(size_t'(req_size), req_addr[1:0]) ||
                    (req_addr >= 32'(MEM_WORDS * 4));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_bad)                state_nx = ERR;
               else if (!req_we)           state_nx = LOAD;
               else if (req_size == SZ_WORD) state_nx = STORE;
               else                        state_nx = RMW_RD;
            end
         end
         LOAD:   state_nx = RESP;
         RMW_RD: state_nx = STORE;
         STORE:  state_nx = RESP;
         RESP: begin
            resp_valid = 1'b1;
            state_nx   = IDLE;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               size_q  <= size_t'(req_size);
               uns_q   <= req_unsigned;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               if (req_we && (req_size == SZ_WORD)) merge_q <= req_wdata;
            end
            LOAD:    resp_rdata <= ext_w;
            RMW_RD:  merge_q    <= merge_w;
            default: ;
         endcase
      end
   end

   byte_lane u_lane (
      .word   (mem_bus.rdata),
      .wdata  (wdata_q),
      .offset (addr_q[1:0]),
      .size   (size_q),
      .uns    (uns_q),
      .ext    (ext_w),
      .merged (merge_w)
   );

   // Gating with rst_n keeps a reset edge from committing a half-done store.
   assign mem_bus.addr = {addr_q[31:2], 2'b00};
   assign mem_bus.enab = (state == STORE) & rst_n;
   assign write_data   = merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   localparam int MW = 64;

   ctrl_bus_if cb ();
   mem_bus_if  mb ();

   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata, write_data;

   mem_access_unit #(.MEM_WORDS(MW)) dut (
      .ctrl_bus     (cb),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_bus      (mb),
      .write_data   (write_data)
   );

   logic [31:0] ram [MW];
   logic        ram_clr;
   assign mb.rdata = ram[mb.addr[7:2]];

   always @(posedge cb.clk) begin
      if (ram_clr) begin
         for (int i = 0; i < MW; i++) ram[i] <= '0;
      end else if (mb.enab) begin
         ram[mb.addr[7:2]] <= write_data;
      end
   end

   initial begin
      cb.clk = 1'b0;
      forever #5 cb.clk = ~cb.clk;
   end

   int cyc = 0;
   always @(posedge cb.clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Reference model state: expected timeline of the current transaction.
   logic [31:0] ref_mem [MW];
   int          acc_cyc = -100, exp_cyc = -100, wr_cyc = -100, rd_cyc = -100;
   logic        exp_err = 1'b0;
   logic [31:0] old_rd = '0, new_rd = '0, exp_wr = '0, exp_addr = '0;
   bit          chk_en = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit model_err(logic [1:0] sz, logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(MW * 4));
   endfunction

   function automatic logic [31:0] load_val(logic [31:0] w, logic [31:0] a,
                                           logic [1:0] sz, bit uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
      if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
      return w;
   endfunction

   function automatic logic [31:0] store_val(logic [31:0] old, logic [31:0] a,
                                            logic [1:0] sz, logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      if (sz == 2'd0) begin sh = 8 * a[1:0]; mask = 32'hFF << sh;   end
      else if (sz == 2'd1) begin sh = 16 * a[1]; mask = 32'hFFFF << sh; end
      else begin sh = 0; mask = 32'hFFFF_FFFF; end
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   always @(negedge cb.clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(!((cyc > acc_cyc) && (cyc <= exp_cyc))));
         chk("resp_valid", 32'(resp_valid), 32'(cyc == exp_cyc));
         if (cyc == exp_cyc) chk("resp_err", 32'(resp_err), 32'(exp_err));
         chk("resp_rdata", resp_rdata, (cyc >= rd_cyc) ? new_rd : old_rd);
         chk("enab", 32'(mb.enab), 32'(cyc == wr_cyc));
         if (cyc == wr_cyc) begin
            chk("write_data", write_data, exp_wr);
            chk("wr_addr", mb.addr, exp_addr);
         end
      end
   end

   task automatic issue(bit we, logic [1:0] sz, bit uns, logic [31:0] a,
                        logic [31:0] wd, bit poke);
      int          lat, n;
      logic [5:0]  wi;
      logic [31:0] old;
      @(negedge cb.clk);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge cb.clk);
         n++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      wi = a[7:2];
      old = ref_mem[wi];
      acc_cyc = cyc;
      exp_err = model_err(sz, a);
      wr_cyc  = -100;
      if (exp_err) lat = 1;
      else if (!we) begin
         lat    = 2;
         old_rd = (cyc >= rd_cyc) ? new_rd : old_rd;
         new_rd = load_val(old, a, sz, uns);
         rd_cyc = cyc + 2;
      end else begin
         lat      = (sz == 2'd2) ? 2 : 3;
         exp_wr   = store_val(old, a, sz, wd);
         exp_addr = {a[31:2], 2'b00};
         wr_cyc   = cyc + lat - 1;
         ref_mem[wi] = exp_wr;
      end
      exp_cyc = cyc + lat;
      @(posedge cb.clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge cb.clk);
         if (poke && k == 1) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
         end
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      cb.rst_n = 1'b0; ram_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < MW; i++) ref_mem[i] = '0;
      repeat (3) @(posedge cb.clk);
      @(negedge cb.clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_addr", mb.addr, 32'd0);
      chk("rst_enab", 32'(mb.enab), 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      cb.rst_n = 1'b1; ram_clr = 1'b0; chk_en = 1'b1;

      issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
      issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
      chk("lw_0x10", resp_rdata, 32'hDEADBEEF);
      chk("ram_0x10", ram[4], 32'hDEADBEEF);

      issue(1, 2'd2, 0, 32'h20, 32'h11223344, 0);
      issue(1, 2'd0, 0, 32'h22, 32'h000000AA, 1);
      chk("sb_rmw", ram[8], 32'h11AA3344);

      issue(1, 2'd2, 0, 32'h30, 32'h80FF7F01, 0);
      issue(0, 2'd0, 0, 32'h31, 32'h0, 0); chk("lb_0x31", resp_rdata, 32'h0000007F);
      issue(0, 2'd0, 0, 32'h32, 32'h0, 0); chk("lb_0x32", resp_rdata, 32'hFFFFFFFF);
      issue(0, 2'd0, 1, 32'h32, 32'h0, 0); chk("lbu_0x32", resp_rdata, 32'h000000FF);
      issue(0, 2'd1, 0, 32'h32, 32'h0, 0); chk("lh_0x32", resp_rdata, 32'hFFFF80FF);
      issue(0, 2'd1, 1, 32'h32, 32'h0, 0); chk("lhu_0x32", resp_rdata, 32'h000080FF);

      issue(1, 2'd1, 0, 32'h12, 32'h1234BEEF, 0);
      chk("sh_rmw", ram[4], 32'hBEEFBEEF);
      issue(1, 2'd0, 0, 32'h10, 32'h00000055, 0);
      chk("sb_lane0", ram[4], 32'hBEEFBE55);

      issue(0, 2'd1, 0, 32'h05, 32'h0, 0);
      issue(1, 2'd2, 0, 32'h06, 32'hCAFEF00D, 0);
      issue(1, 2'd2, 0, 32'h100, 32'hCAFEF00D, 0);
      issue(0, 2'd3, 0, 32'h00, 32'h0, 0);
      chk("err_ram1", ram[1], 32'h0);
      chk("err_ram0", ram[0], 32'h0);
      chk("err_keeps_rdata", resp_rdata, 32'h000080FF);

      issue(1, 2'd2, 0, 32'hFC, 32'h0BADF00D, 0);
      issue(0, 2'd2, 0, 32'hFC, 32'h0, 0);
      chk("lw_last", resp_rdata, 32'h0BADF00D);

      // Reset while the word store sits in STORE.
      chk_en = 1'b0;
      @(negedge cb.clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h44;
      req_wdata = 32'h12345678;
      @(posedge cb.clk);
      #1 req_valid = 1'b0;
      @(negedge cb.clk);
      chk("store_enab_pre", 32'(mb.enab), 32'd1);
      cb.rst_n = 1'b0;
      #1 chk("enab_in_rst", 32'(mb.enab), 32'd0);
      @(negedge cb.clk);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_rdata", resp_rdata, 32'd0);
      chk("mid_rst_addr", mb.addr, 32'd0);
      chk("mid_rst_wdata", write_data, 32'd0);
      chk("mid_rst_ram", ram[17], 32'd0);
      cb.rst_n = 1'b1;
      @(negedge cb.clk);
      chk("post_rst_valid", 32'(resp_valid), 32'd0);
      old_rd = '0; new_rd = '0; rd_cyc = -100;
      acc_cyc = -100; exp_cyc = -100; wr_cyc = -100;
      chk_en = 1'b1;

      issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
      chk("lw_after_rst", resp_rdata, 32'hBEEFBE55);
      issue(0, 2'd2, 0, 32'h44, 32'h0, 0);
      chk("lw_dropped", resp_rdata, 32'h0);

      @(negedge cb.clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
